uart_regs: RTL and testbench

- Memory-mapped UART peripheral in the 0xFF00-0xFFFF register space; drives register_bus_data_in and register_bus_wait at SoC level.
- Decodes the low address byte, buffers CPU writes in a TX FIFO, and serialises them as 8N1.
- Optionally receives 8N1 into a one-byte holding register.
- The bus strobes it receives are already gated by the register-space decode.

---
 rtl/duck_uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_regs.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_regs.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duck_uart_pkg.sv
// Shared definitions for the uart_regs peripheral: register offsets,
// STATUS bit positions and the serial-engine state encoding.
package duck_uart_pkg;

   // Register offsets within the 0xFF00-0xFFFF window (low address byte)
   localparam logic [7:0] REG_DATA   = 8'h00;
   localparam logic [7:0] REG_STATUS = 8'h01;
   localparam logic [7:0] REG_DIV_LO = 8'h02;
   localparam logic [7:0] REG_DIV_HI = 8'h03;

   // STATUS register bit positions
   localparam int unsigned ST_TX_FULL    = 0;
   localparam int unsigned ST_TX_EMPTY   = 1;
   localparam int unsigned ST_TX_BUSY    = 2;
   localparam int unsigned ST_RX_VALID   = 3;
   localparam int unsigned ST_RX_OVERRUN = 4;

   // Shared by the transmit and receive engines
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Parameterised synchronous FIFO with combinational read port.
// DEPTH must be a power of two (pointers wrap naturally); push and pop
// in the same cycle are accepted at any occupancy.
module uart_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned   PW       = $clog2(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [PW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full      = (count_r == CNT_FULL);
   assign empty     = (count_r == CNT_ZERO);
   assign do_pop_s  = pop && !empty;
   // A pop frees the slot being written, so push is legal even when full
   assign do_push_s = push && (!full || do_pop_s);
   assign pop_data  = mem_r[rd_ptr_r];

   // Storage array write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= CNT_ZERO;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/uart_regs.sv
// Memory-mapped 8N1 UART: register decode, TX FIFO with bus stall,
// transmit serialiser and optional receiver.
// Optional receiver is built when the macro UART_RX_EN is defined;
// without it uart_rx is ignored and rx_valid/overrun/DATA reads are 0.
module uart_regs
   import duck_uart_pkg::*;
#(
   parameter int unsigned TX_FIFO_DEPTH = 4,
   parameter logic [15:0] DEFAULT_DIV   = 16'd103
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] bus_address,
   input  logic [7:0] bus_data_tx,
   output logic [7:0] bus_data_rx,
   input  logic       bus_read,
   input  logic       bus_write,
   output logic       bus_wait,
   output logic       uart_tx,
   input  logic       uart_rx
);

   logic        wr_d_r;
   logic        wr_start_s;
   logic        wr_data_start_s;
   logic        pending_r;
   logic        push_s;
   logic [15:0] div_r;

   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic [7:0]  fifo_rdata_s;
   logic        tx_pop_s;

   uart_state_e tx_state_r;
   logic [15:0] tx_cnt_r;
   logic [15:0] tx_div_r;
   logic [2:0]  tx_bit_r;
   logic [7:0]  tx_shift_r;
   logic        tx_r;

   logic        rx_valid_s;
   logic        rx_overrun_s;
   logic [7:0]  rx_data_s;
   logic [7:0]  status_s;

   // Access start is the rising edge of the held strobe
   assign wr_start_s      = bus_write && !wr_d_r;
   assign wr_data_start_s = wr_start_s && (bus_address == REG_DATA);
   // A DATA write is pushed in the first cycle the FIFO has room
   assign push_s          = (wr_data_start_s || pending_r) && !fifo_full_s;
   assign bus_wait        = (wr_data_start_s || pending_r) && fifo_full_s;
   assign uart_tx         = tx_r;

   // Write-strobe history and pending full-FIFO write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_d_r    <= 1'b0;
         pending_r <= 1'b0;
      end else begin
         wr_d_r <= bus_write;
         if (wr_data_start_s && fifo_full_s) begin
            pending_r <= 1'b1;
         end else if (pending_r && !fifo_full_s) begin
            pending_r <= 1'b0;
         end
      end
   end

   // Baud divisor register; a running frame keeps its latched copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= DEFAULT_DIV;
      end else if (wr_start_s && (bus_address == REG_DIV_LO)) begin
         div_r[7:0] <= bus_data_tx;
      end else if (wr_start_s && (bus_address == REG_DIV_HI)) begin
         div_r[15:8] <= bus_data_tx;
      end
   end

   uart_fifo #(
      .DEPTH (TX_FIFO_DEPTH),
      .WIDTH (8)
   ) u_tx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (bus_data_tx),
      .pop       (tx_pop_s),
      .pop_data  (fifo_rdata_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Load a new frame from IDLE, or straight from the end of STOP so frames abut
   always_comb begin
      tx_pop_s = 1'b0;
      if (fifo_empty_s) begin
         tx_pop_s = 1'b0;
      end else if (tx_state_r == IDLE) begin
         tx_pop_s = 1'b1;
      end else if ((tx_state_r == STOP) && (tx_cnt_r == tx_div_r)) begin
         tx_pop_s = 1'b1;
      end else begin
         tx_pop_s = 1'b0;
      end
   end

   // Transmit serialiser: start bit, 8 data bits LSB first, stop bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_r <= IDLE;
         tx_cnt_r   <= 16'd0;
         tx_div_r   <= 16'd0;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'h00;
         tx_r       <= 1'b1;
      end else if (tx_pop_s) begin
         tx_state_r <= START;
         tx_cnt_r   <= 16'd0;
         tx_div_r   <= div_r;
         tx_shift_r <= fifo_rdata_s;
         tx_r       <= 1'b0;
      end else begin
         case (tx_state_r)
            IDLE: begin
               tx_r <= 1'b1;
            end
            START: begin
               if (tx_cnt_r == tx_div_r) begin
                  tx_cnt_r   <= 16'd0;
                  tx_bit_r   <= 3'd0;
                  tx_state_r <= DATA;
                  tx_r       <= tx_shift_r[0];
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            DATA: begin
               if (tx_cnt_r == tx_div_r) begin
                  tx_cnt_r <= 16'd0;
                  if (tx_bit_r == 3'd7) begin
                     tx_state_r <= STOP;
                     tx_r       <= 1'b1;
                  end else begin
                     tx_bit_r   <= tx_bit_r + 3'd1;
                     tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                     tx_r       <= tx_shift_r[1];
                  end
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            STOP: begin
               if (tx_cnt_r == tx_div_r) begin
                  tx_state_r <= IDLE;
                  tx_cnt_r   <= 16'd0;
               end else begin
                  tx_cnt_r <= tx_cnt_r + 16'd1;
               end
            end
            default: begin
               tx_state_r <= IDLE;
               tx_r       <= 1'b1;
            end
         endcase
      end
   end

`ifdef UART_RX_EN
   logic        rd_d_r;
   logic        rd_start_s;
   logic        rx_clr_s;
   logic        status_rd_s;
   logic        rx_s1_r;
   logic        rx_s2_r;
   logic        rx_prev_r;
   uart_state_e rx_state_r;
   logic [15:0] rx_cnt_r;
   logic [15:0] rx_div_r;
   logic [2:0]  rx_bit_r;
   logic [7:0]  rx_shift_r;
   logic [7:0]  rx_data_r;
   logic        rx_valid_r;
   logic        rx_overrun_r;
   logic        rx_load_s;
   logic        rx_ovr_set_s;

   assign rd_start_s   = bus_read && !rd_d_r;
   assign rx_clr_s     = rd_start_s && (bus_address == REG_DATA) && rx_valid_r;
   assign status_rd_s  = rd_start_s && (bus_address == REG_STATUS);
   assign rx_valid_s   = rx_valid_r;
   assign rx_overrun_s = rx_overrun_r;
   assign rx_data_s    = rx_data_r;

   // Read-strobe history and two-flop synchroniser for uart_rx
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_d_r    <= 1'b0;
         rx_s1_r   <= 1'b1;
         rx_s2_r   <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rd_d_r    <= bus_read;
         rx_s1_r   <= uart_rx;
         rx_s2_r   <= rx_s1_r;
         rx_prev_r <= rx_s2_r;
      end
   end

   // Good stop bit: load the byte, or flag overrun unless a read frees the holder now
   always_comb begin
      rx_load_s    = 1'b0;
      rx_ovr_set_s = 1'b0;
      if (!((rx_state_r == STOP) && (rx_cnt_r == rx_div_r) && rx_s2_r)) begin
         rx_load_s    = 1'b0;
         rx_ovr_set_s = 1'b0;
      end else if (rx_valid_r && !rx_clr_s) begin
         rx_ovr_set_s = 1'b1;
      end else begin
         rx_load_s = 1'b1;
      end
   end

   // Receive deserialiser with mid-bit sampling and false-start rejection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_r <= IDLE;
         rx_cnt_r   <= 16'd0;
         rx_div_r   <= 16'd0;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'h00;
      end else begin
         case (rx_state_r)
            IDLE: begin
               if (rx_prev_r && !rx_s2_r) begin
                  rx_state_r <= START;
                  rx_cnt_r   <= 16'd0;
                  rx_div_r   <= div_r;
               end
            end
            START: begin
               if (rx_cnt_r == (rx_div_r >> 1)) begin
                  rx_cnt_r <= 16'd0;
                  rx_bit_r <= 3'd0;
                  if (rx_s2_r) begin
                     rx_state_r <= IDLE;
                  end else begin
                     rx_state_r <= DATA;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + 16'd1;
               end
            end
            DATA: begin
               if (rx_cnt_r == rx_div_r) begin
                  rx_cnt_r   <= 16'd0;
                  rx_shift_r <= {rx_s2_r, rx_shift_r[7:1]};
                  if (rx_bit_r == 3'd7) begin
                     rx_state_r <= STOP;
                  end else begin
                     rx_bit_r <= rx_bit_r + 3'd1;
                  end
               end else begin
                  rx_cnt_r <= rx_cnt_r + 16'd1;
               end
            end
            STOP: begin
               if (rx_cnt_r == rx_div_r) begin
                  rx_cnt_r   <= 16'd0;
                  rx_state_r <= IDLE;
               end else begin
                  rx_cnt_r <= rx_cnt_r + 16'd1;
               end
            end
            default: begin
               rx_state_r <= IDLE;
            end
         endcase
      end
   end

   // Holding register, valid flag and sticky overrun
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data_r    <= 8'h00;
         rx_valid_r   <= 1'b0;
         rx_overrun_r <= 1'b0;
      end else begin
         if (rx_load_s) begin
            rx_data_r  <= rx_shift_r;
            rx_valid_r <= 1'b1;
         end else if (rx_clr_s) begin
            rx_valid_r <= 1'b0;
         end
         if (rx_ovr_set_s) begin
            rx_overrun_r <= 1'b1;
         end else if (status_rd_s) begin
            rx_overrun_r <= 1'b0;
         end
      end
   end
`else
   logic unused_s;

   assign unused_s     = ^{uart_rx, bus_read};
   assign rx_valid_s   = 1'b0;
   assign rx_overrun_s = 1'b0;
   assign rx_data_s    = 8'h00;
`endif

   // STATUS register assembly
   always_comb begin
      status_s                = 8'h00;
      status_s[ST_TX_FULL]    = fifo_full_s;
      status_s[ST_TX_EMPTY]   = fifo_empty_s;
      status_s[ST_TX_BUSY]    = (tx_state_r != IDLE) || !fifo_empty_s;
      status_s[ST_RX_VALID]   = rx_valid_s;
      status_s[ST_RX_OVERRUN] = rx_overrun_s;
   end

   // Read data mux, combinational from address and registers
   always_comb begin
      bus_data_rx = 8'h00;
      case (bus_address)
         REG_DATA: begin
            if (rx_valid_s) begin
               bus_data_rx = rx_data_s;
            end else begin
               bus_data_rx = 8'h00;
            end
         end
         REG_STATUS: bus_data_rx = status_s;
         REG_DIV_LO: bus_data_rx = div_r[7:0];
         REG_DIV_HI: bus_data_rx = div_r[15:8];
         default:    bus_data_rx = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_uart_regs.sv
// Scoreboard bench for uart_regs: reads and transmitted frames are checked
// by independent monitors against expectations queued by the stimulus.
module tb_uart_regs;

   logic       clk;
   logic       rst_n;
   logic [7:0] bus_address;
   logic [7:0] bus_data_tx;
   logic [7:0] bus_data_rx;
   logic       bus_read;
   logic       bus_write;
   logic       bus_wait;
   logic       uart_tx;
   logic       uart_rx;

`ifdef UART_RX_EN
   localparam bit RX_EN = 1'b1;
`else
   localparam bit RX_EN = 1'b0;
`endif

   uart_regs #(.TX_FIFO_DEPTH(4), .DEFAULT_DIV(16'd103)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_address (bus_address),
      .bus_data_tx (bus_data_tx),
      .bus_data_rx (bus_data_rx),
      .bus_read    (bus_read),
      .bus_write   (bus_write),
      .bus_wait    (bus_wait),
      .uart_tx     (uart_tx),
      .uart_rx     (uart_rx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      nm;
      logic [7:0] exp;
   } rd_exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   rd_exp_t     rd_q[$];
   logic [7:0]  tx_q[$];
   logic [15:0] tb_div   = 16'd103;
   int          rst_epoch = 0;
   bit          b2b_chk  = 1'b0;
   longint      last_fall = -1;

   // Receiver reference model
   bit          m_valid = 1'b0;
   bit          m_ovr   = 1'b0;
   logic [7:0]  m_data  = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Read monitor: compares the first cycle of each read access
   initial begin : rd_mon
      logic    prev;
      rd_exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (bus_read && !prev) begin
            if (rd_q.size() == 0) begin
               chk("unexpected_read", 32'd1, 32'd0);
            end else begin
               e = rd_q.pop_front();
               chk(e.nm, {24'd0, bus_data_rx}, {24'd0, e.exp});
            end
         end
         prev = bus_read;
      end
   end

   // Serial monitor: decodes 8N1 frames on uart_tx at the bench's divisor
   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      logic       stop_v;
      int         p;
      int         ep;
      logic [7:0] e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && !uart_tx && rst_n) begin
            p  = int'(tb_div) + 1;
            ep = rst_epoch;
            if (b2b_chk && last_fall >= 0) begin
               chk("frame_spacing", 32'(longint'(cyc) - last_fall), 32'(10 * p));
            end
            last_fall = longint'(cyc);
            repeat (p / 2) @(negedge clk);
            if (ep == rst_epoch) chk("start_bit", {31'd0, uart_tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
               repeat (p) @(negedge clk);
               b[i] = uart_tx;
            end
            repeat (p) @(negedge clk);
            stop_v = uart_tx;
            if (ep == rst_epoch) begin
               chk("stop_bit", {31'd0, stop_v}, 32'd1);
               if (tx_q.size() == 0) begin
                  chk("unexpected_frame", {24'd0, b}, 32'hFFFF_FFFF);
               end else begin
                  e = tx_q.pop_front();
                  chk("tx_byte", {24'd0, b}, {24'd0, e});
               end
            end
         end
         prev = uart_tx;
      end
   end

   task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, output int waits);
      waits = 0;
      @(posedge clk); #1;
      bus_address = a;
      bus_data_tx = d;
      bus_write   = 1'b1;
      if (a == 8'h00) tx_q.push_back(d);
      @(negedge clk);
      while (bus_wait && waits < 5000) begin
         waits++;
         @(negedge clk);
      end
      if (bus_wait) chk("wait_timeout", 32'd1, 32'd0);
      if (a == 8'h02) tb_div[7:0]  = d;
      if (a == 8'h03) tb_div[15:8] = d;
      @(posedge clk); #1;
      bus_write = 1'b0;
   endtask

   task automatic bus_rd(input string nm, input logic [7:0] a, input logic [7:0] exp, input int hold);
      rd_exp_t e;
      e.nm  = nm;
      e.exp = exp;
      rd_q.push_back(e);
      @(posedge clk); #1;
      bus_address = a;
      bus_read    = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      bus_read = 1'b0;
   endtask

   task automatic set_div(input logic [15:0] dv);
      int w;
      bus_wr(8'h02, dv[7:0], w);
      bus_wr(8'h03, dv[15:8], w);
   endtask

   // STATUS with the transmitter idle, expectation from the RX model
   task automatic rd_status(input string nm);
      logic [7:0] e;
      e = 8'h02 | {3'b000, m_ovr, m_valid, 3'b000};
      bus_rd(nm, 8'h01, e, 1);
      m_ovr = 1'b0;
   endtask

   task automatic rd_data(input string nm, input int hold);
      logic [7:0] e;
      e = m_valid ? m_data : 8'h00;
      bus_rd(nm, 8'h00, e, hold);
      m_valid = 1'b0;
   endtask

   task automatic wait_tx_idle();
      int t;
      t = 0;
      while (tx_q.size() != 0 && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk("tx_drain_timeout", tx_q.size(), 32'd0);
      repeat (2 * (int'(tb_div) + 1)) @(negedge clk);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      int         p;
      fr = {stop_bit, b, 1'b0};
      p  = int'(tb_div) + 1;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         #1 uart_rx = fr[i];
         repeat (p) @(posedge clk);
      end
      #1 uart_rx = 1'b1;
      repeat (4) @(posedge clk);
      if (RX_EN && stop_bit) begin
         if (m_valid) begin
            m_ovr = 1'b1;
         end else begin
            m_valid = 1'b1;
            m_data  = b;
         end
      end
   endtask

   initial begin : stim
      int         w;
      int         nb;
      logic [7:0] d;
      int         waits[6];

      rst_n = 1'b1; bus_address = 8'h00; bus_data_tx = 8'h00;
      bus_read = 1'b0; bus_write = 1'b0; uart_rx = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
      chk("reset_bus_wait", {31'd0, bus_wait}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset values
      rd_status("reset_status");
      bus_rd("reset_div_lo", 8'h02, 8'h67, 1);
      bus_rd("reset_div_hi", 8'h03, 8'h00, 1);
      bus_rd("unmapped_read", 8'h7E, 8'h00, 1);
      bus_wr(8'h7E, 8'h5A, w);
      bus_rd("unmapped_after_write", 8'h7E, 8'h00, 1);

      // Single byte at DIV=3
      set_div(16'd3);
      bus_rd("div_lo_rb", 8'h02, 8'h03, 1);
      bus_wr(8'h00, 8'hA5, w);
      bus_rd("status_busy", 8'h01, 8'h06, 1);
      wait_tx_idle();
      rd_status("status_after_frame");

      // FIFO full: six back-to-back writes, sixth stalls
      b2b_chk = 1'b1;
      last_fall = -1;
      for (int i = 0; i < 6; i++) begin
         d = 8'($urandom_range(0, 255));
         bus_wr(8'h00, d, waits[i]);
      end
      for (int i = 0; i < 5; i++) chk("wr_no_wait", waits[i], 32'd0);
      chk("wr6_waited", {31'd0, waits[5] > 0}, 32'd1);
      bus_rd("status_full", 8'h01, 8'h05, 1);
      wait_tx_idle();
      b2b_chk = 1'b0;
      rd_status("status_after_burst");

      // Randomised divisors and payloads
      for (int r = 0; r < 3; r++) begin
         set_div(16'($urandom_range(2, 7)));
         bus_rd("div_lo_rand", 8'h02, tb_div[7:0], 1);
         nb = $urandom_range(1, 5);
         for (int i = 0; i < nb; i++) bus_wr(8'h00, 8'($urandom_range(0, 255)), w);
         wait_tx_idle();
         rd_status("status_rand");
      end

      // Receiver
      set_div(16'd15);
      rx_send(8'($urandom_range(0, 255)), 1'b1);
      rd_status("rx_status_valid");
      rd_data("rx_data_rand", 1);
      rd_status("rx_status_cleared");

      rx_send(8'h3C, 1'b1);
      rx_send(8'h81, 1'b1);
      rd_data("rx_overrun_data", 1);
      rd_status("rx_overrun_status1");
      rd_status("rx_overrun_status2");

      rx_send(8'($urandom_range(0, 255)), 1'b1);
      rd_data("rx_held_read", 10);
      rd_status("rx_after_held_read");
      rd_data("rx_data_empty", 1);

      @(posedge clk); #1 uart_rx = 1'b0;
      @(posedge clk); #1 uart_rx = 1'b1;
      repeat (48) @(posedge clk);
      rd_status("rx_false_start");

      rx_send(8'($urandom_range(0, 255)), 1'b0);
      repeat (20) @(posedge clk);
      rd_status("rx_bad_stop");

      // Reset in the middle of a frame
      bus_wr(8'h00, 8'h55, w);
      repeat (10) @(negedge clk);
      chk("tx_before_reset", {31'd0, uart_tx}, 32'd0);
      rst_epoch++;
      rst_n = 1'b0;
      #1;
      chk("tx_async_reset", {31'd0, uart_tx}, 32'd1);
      tx_q.delete();
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      tb_div  = 16'd103;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      rd_status("status_after_reset");
      bus_rd("div_lo_after_reset", 8'h02, 8'h67, 1);
      repeat (4) @(posedge clk);
      chk("read_queue_drained", rd_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
